fu_result_packer: RTL and testbench
===================================

Name: fu_result_packer

Overview:
- Sits at the output end of the single-FU datapath.
- Consumes the FU's 16-bit result stream (dout/dout_v bursts) and packs pairs of results into 32-bit words.
- Buffers the packed words in a small FIFO and drives them into the 32-bit host read FIFO (Xillybus side) using a write/full handshake.
- The FU cannot stall, so this block absorbs host backpressure and flags any loss.

Parameters:
DEPTH_LOG2, 4, log2 of internal FIFO depth in 32-bit words (default 16 entries)
PAD_VALUE, 16'h0000, upper-half filler for odd-length bursts

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
din  in  16  FU result word (FU dout)
din_v  in  1  FU result valid (FU dout_v); a burst is a contiguous run of din_v high
host_full  in  1  host read FIFO full
dout  out  32  packed word to host FIFO
dout_wr  out  1  host FIFO write strobe
level  out  DEPTH_LOG2+1  words currently held in the internal FIFO
overflow  out  1  sticky: at least one packed word was dropped

Behaviour:
- Reset (async, rst=1): state EMPTY, pending half cleared, FIFO emptied, din_v_d1=0, dout=0, dout_wr=0, level=0, overflow=0. A reset mid-burst discards the pending half and all buffered words.
- Burst end detection: registered din_v_d1; end = din_v_d1 & ~din_v.
- Packing FSM:
  - EMPTY, din_v=1: latch din into lo; go to HALF. No push.
  - HALF, din_v=1: push {din, lo} (second word in [31:16], first in [15:0]); go to EMPTY.
  - HALF, end=1: push {PAD_VALUE, lo}; go to EMPTY.
  - EMPTY, end=1: no push.
  - Any other input leaves the state unchanged.
- Packing is strictly per burst; halves from different bursts never combine.
- Push to full FIFO (level == 2**DEPTH_LOG2): the word is dropped, FIFO contents are unchanged, and overflow is set (sticky until reset).
- Output side: the FIFO is first-word-fall-through.
  - dout_wr = (level != 0) & ~host_full. While it is high, dout = FIFO head, and the head pops on the same clock edge.
  - When dout_wr = 0, dout holds its last value.
- Simultaneous push and pop: both occur; level is unchanged. This is allowed when the FIFO is full, provided a pop also occurs that cycle (no drop).
- Latency: a word pushed at edge N can appear with dout_wr=1 in cycle N+1 at the earliest.
- FIFO pointers are DEPTH_LOG2 bits and wrap naturally; level is the full/empty discriminator.

Optional Feature:
Macro FU_PACK_TRAILER_EN.
- Defined:
  - A 16-bit burst counter counts din_v-high cycles and saturates at 16'hFFFF.
  - On burst end the FSM enters TRAILER for one cycle and pushes {16'hB5E0, burst_count}, then returns to EMPTY. The counter clears at that point.
  - If din_v rises during the TRAILER cycle, that word latches into lo and the FSM moves to HALF after the trailer push.
  - This case cannot produce two pushes in one cycle.
  - The trailer follows the padded/flushed word.
- Undefined: no TRAILER state and no counter; behaviour exactly as above.

Decomposition:
- Package fu_pack_pkg:
  - state enum {EMPTY, HALF, TRAILER}
  - TRAILER_MAGIC = 16'hB5E0
  - default PAD_VALUE
  - pack-word width constant (32)
- One sub-module, fu_pack_fifo:
  - synchronous FWFT FIFO, parameterised by width and DEPTH_LOG2
  - async reset
  - push/pop/level/full/empty
  - drop-on-full, reported back to the top for overflow.

Test Plan:
1. Reset; host_full=0; burst 0x0001,0x0002,0x0003,0x0004 -> dout_wr pulses twice: 0x00020001 then 0x00040003; level returns to 0; overflow=0.
2. Odd burst 0x0011,0x0022,0x0033 -> 0x00220011, then 0x00000033 (pad pushed on the falling cycle).
3. Two bursts (0x00AA) and (0x00BB) separated by one idle cycle -> 0x000000AA, 0x000000BB; never 0x00BB00AA.
4. host_full=1; 40-word burst (20 packs):
   - level saturates at 16; overflow=1; 4 words dropped.
   - Release host_full -> exactly 16 words out, in order, starting at 0x00020001-pattern data.
   - overflow stays 1.
5. Assert rst asynchronously mid-burst, with one half pending and 3 words buffered -> dout=0, dout_wr=0 and level=0 immediately. After release, a fresh burst packs correctly with no stale lo.
6. FU_PACK_TRAILER_EN defined; burst of 3 words -> outputs {w2,w1}, {PAD,w3}, 0xB5E00003. A second burst starting in the trailer cycle packs its first word correctly.

Source files
------------

// File: rtl/fu_pack_pkg.sv
// rtl/fu_pack_pkg.sv - shared types and constants for the FU result packer
package fu_pack_pkg;
   localparam int          PACK_W        = 32;
   localparam logic [15:0] TRAILER_MAGIC = 16'hB5E0;
   localparam logic [15:0] PAD_DEFAULT   = 16'h0000;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      HALF    = 2'd1,
      TRAILER = 2'd2
   } pack_state_e;
endpackage

// File: rtl/fu_pack_fifo.sv
// rtl/fu_pack_fifo.sv - first-word-fall-through FIFO that drops pushes when full
// A push into a full FIFO still lands if a pop frees a slot in the same cycle.
module fu_pack_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      push_data_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      head_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  empty_o,
   output logic                  drop_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q;
   logic                  full, do_push, do_pop;

   // level never exceeds DEPTH, so its top bit alone means full
   assign full    = level_q[DEPTH_LOG2];
   assign empty_o = (level_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full | do_pop);
   assign drop_o  = push_i & full & ~do_pop;
   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_q + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end
endmodule

// File: rtl/fu_result_packer.sv
// rtl/fu_result_packer.sv - packs 16-bit FU result bursts into 32-bit host FIFO words
// Optional per-burst trailer word {B5E0, count}: define FU_PACK_TRAILER_EN.
module fu_result_packer
   import fu_pack_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 4,
   parameter logic [15:0] PAD_VALUE  = PAD_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           din,
   input  logic                  din_v,
   input  logic                  host_full,
   output logic [PACK_W-1:0]     dout,
   output logic                  dout_wr,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);
`ifdef FU_PACK_TRAILER_EN
   localparam pack_state_e END_STATE = TRAILER;
`else
   localparam pack_state_e END_STATE = EMPTY;
`endif

   pack_state_e       state_q, state_d;
   logic [15:0]       lo_q;
   logic              din_v_d1_q, burst_end;
   logic              push, lo_load;
   logic [PACK_W-1:0] push_data, fifo_head, dout_q;
   logic              fifo_empty, fifo_drop, overflow_q;

   assign burst_end = din_v_d1_q & ~din_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         din_v_d1_q <= 1'b0;
         lo_q       <= '0;
         dout_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         din_v_d1_q <= din_v;
         if (lo_load) lo_q <= din;
         if (dout_wr) dout_q <= dout;
         overflow_q <= overflow_q | fifo_drop;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (din_v) state_d = HALF;  else if (burst_end) state_d = END_STATE;
         HALF:    if (din_v) state_d = EMPTY; else if (burst_end) state_d = END_STATE;
`ifdef FU_PACK_TRAILER_EN
         TRAILER: state_d = din_v ? HALF : EMPTY;
`endif
         default: state_d = EMPTY;
      endcase
   end

`ifdef FU_PACK_TRAILER_EN
   logic [15:0] burst_cnt_q;

   // A word arriving in the trailer cycle already belongs to the next burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          burst_cnt_q <= '0;
      else if (state_q == TRAILER)      burst_cnt_q <= din_v ? 16'd1 : 16'd0;
      else if (din_v && burst_cnt_q != 16'hFFFF) burst_cnt_q <= burst_cnt_q + 16'd1;
   end
`endif

   always_comb begin
      push      = 1'b0;
      lo_load   = 1'b0;
      push_data = {PAD_VALUE, lo_q};
      case (state_q)
         EMPTY: lo_load = din_v;
         HALF: begin
            if (din_v) begin
               push      = 1'b1;
               push_data = {din, lo_q};
            end else if (burst_end) begin
               push = 1'b1;
            end
         end
`ifdef FU_PACK_TRAILER_EN
         TRAILER: begin
            push      = 1'b1;
            push_data = {TRAILER_MAGIC, burst_cnt_q};
            lo_load   = din_v;
         end
`endif
         default: ;
      endcase
   end

   fu_pack_fifo #(
      .WIDTH      (PACK_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (dout_wr),
      .head_o      (fifo_head),
      .level_o     (level),
      .empty_o     (fifo_empty),
      .drop_o      (fifo_drop)
   );

   assign dout_wr  = ~fifo_empty & ~host_full;
   assign dout     = dout_wr ? fifo_head : dout_q;
   assign overflow = overflow_q;
endmodule

// File: tb/tb_fu_result_packer.sv
// tb/tb_fu_result_packer.sv - self-checking bench for fu_result_packer (FU_PACK_TRAILER_EN aware)
module tb_fu_result_packer;
   localparam int DL    = 4;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic        din_v;
   logic        host_full;
   logic [31:0] dout;
   logic        dout_wr;
   logic [DL:0] level;
   logic        overflow;

   always #5 clk = ~clk;

   fu_result_packer #(.DEPTH_LOG2(DL), .PAD_VALUE(16'h0000)) dut (
      .clk(clk), .rst(rst), .din(din), .din_v(din_v), .host_full(host_full),
      .dout(dout), .dout_wr(dout_wr), .level(level), .overflow(overflow)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: burst-level view of packing plus a plain queue for the FIFO
   logic [31:0] m_fifo[$];
   logic [15:0] m_burst[$];
   logic [31:0] m_last;
   bit          m_ovf;
   bit          m_prev_v;
   int          m_drops;
   bit          m_tr_due;
   int          m_cnt;
   int          m_tr_cnt;
   logic [31:0] seen[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] seen_at(input int k);
      if (k < seen.size()) return seen[k];
      return 32'hDEAD_DEAD;
   endfunction

   task automatic model_reset();
      m_fifo.delete(); m_burst.delete();
      m_last = '0; m_ovf = 0; m_prev_v = 0; m_drops = 0;
      m_tr_due = 0; m_cnt = 0; m_tr_cnt = 0;
   endtask

   task automatic compare();
      bit          e_wr;
      logic [31:0] e_dout;
      e_wr   = (m_fifo.size() != 0) && !host_full;
      e_dout = e_wr ? m_fifo[0] : m_last;
      chk("dout_wr", {31'b0, dout_wr}, {31'b0, e_wr});
      chk("dout", dout, e_dout);
      chk("level", {27'b0, level}, m_fifo.size());
      chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      if (dout_wr) seen.push_back(dout);
   endtask

   // effect of the coming rising edge given the inputs now applied
   task automatic model_edge();
      logic [31:0] pushes[$];
      bit pop, full_before;
      pop         = (m_fifo.size() != 0) && !host_full;
      full_before = (m_fifo.size() == DEPTH);
`ifdef FU_PACK_TRAILER_EN
      if (m_tr_due) begin
         pushes.push_back({16'hB5E0, m_tr_cnt[15:0]});
         m_tr_due = 0;
      end
`endif
      if (din_v) begin
         m_burst.push_back(din);
         if (m_cnt < 65535) m_cnt++;
         if (m_burst.size() == 2) begin
            pushes.push_back({m_burst[1], m_burst[0]});
            m_burst.delete();
         end
      end else if (m_prev_v) begin
         if (m_burst.size() == 1) pushes.push_back({16'h0000, m_burst[0]});
         m_burst.delete();
`ifdef FU_PACK_TRAILER_EN
         m_tr_due = 1;
         m_tr_cnt = m_cnt;
`endif
         m_cnt = 0;
      end
      if (pop) m_last = m_fifo.pop_front();
      foreach (pushes[i]) begin
         if (full_before && !pop) begin
            m_ovf = 1;
            m_drops++;
         end else begin
            m_fifo.push_back(pushes[i]);
         end
      end
      m_prev_v = din_v;
   endtask

   task automatic tick(input bit v, input logic [15:0] d, input bit hf);
      @(negedge clk);
      din_v = v; din = d; host_full = hf;
      #1;
      compare();
      model_edge();
   endtask

   task automatic send_seq(input int n, input logic [15:0] start, input logic [15:0] step, input bit hf);
      logic [15:0] w;
      w = start;
      for (int i = 0; i < n; i++) begin
         tick(1'b1, w, hf);
         w = w + step;
      end
   endtask

   task automatic idle(input int n, input bit hf);
      for (int i = 0; i < n; i++) tick(1'b0, 16'h0, hf);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; din_v = 1'b0; din = '0; host_full = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      bit hf_bias;
      bit v;
      rst = 1'b1; din_v = 1'b0; din = '0; host_full = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // even burst
      seen.delete();
      idle(1, 0);
      send_seq(4, 16'h0001, 16'h0001, 0);
      idle(6, 0);
      chk("t1_word0", seen_at(0), 32'h0002_0001);
      chk("t1_word1", seen_at(1), 32'h0004_0003);
`ifdef FU_PACK_TRAILER_EN
      chk("t1_trailer", seen_at(2), 32'hB5E0_0004);
      chk("t1_count", seen.size(), 3);
`else
      chk("t1_count", seen.size(), 2);
`endif
      chk("t1_level", {27'b0, level}, 0);
      chk("t1_overflow", {31'b0, overflow}, 0);

      // odd burst pads the upper half
      seen.delete();
      send_seq(3, 16'h0011, 16'h0011, 0);
      idle(6, 0);
      chk("t2_word0", seen_at(0), 32'h0022_0011);
      chk("t2_pad", seen_at(1), 32'h0000_0033);
`ifdef FU_PACK_TRAILER_EN
      chk("t2_trailer", seen_at(2), 32'hB5E0_0003);
`endif

      // single-word bursts one idle apart never merge
      seen.delete();
      send_seq(1, 16'h00AA, 16'h0, 0);
      idle(1, 0);
      send_seq(1, 16'h00BB, 16'h0, 0);
      idle(6, 0);
      chk("t3_first", seen_at(0), 32'h0000_00AA);
`ifdef FU_PACK_TRAILER_EN
      chk("t3_second", seen_at(2), 32'h0000_00BB);
`else
      chk("t3_second", seen_at(1), 32'h0000_00BB);
`endif
      foreach (seen[i]) if (seen[i] == 32'h00BB_00AA) chk("t3_merged", seen[i], 32'h0000_00BB);

      // backpressure: 20 packs into a 16-deep FIFO
      do_reset();
      seen.delete();
      send_seq(40, 16'h0001, 16'h0001, 1);
      idle(3, 1);
      chk("t4_level_full", {27'b0, level}, 16);
      chk("t4_overflow", {31'b0, overflow}, 1);
`ifdef FU_PACK_TRAILER_EN
      chk("t4_drops", m_drops, 5);
`else
      chk("t4_drops", m_drops, 4);
`endif
      idle(30, 0);
      chk("t4_out_count", seen.size(), 16);
      chk("t4_first", seen_at(0), 32'h0002_0001);
      chk("t4_last", seen_at(15), 32'h0020_001F);
      chk("t4_overflow_sticky", {31'b0, overflow}, 1);

      // asynchronous reset mid-burst with a pending half and 3 buffered words
      do_reset();
      send_seq(7, 16'h0101, 16'h0001, 1);
      chk("t5_pre_level", {27'b0, level}, 3);
      @(negedge clk);
      din_v = 1'b1; din = 16'h0108;
      #2;
      rst = 1'b1; host_full = 1'b0;
      #1;
      chk("t5_rst_dout", dout, 32'h0);
      chk("t5_rst_wr", {31'b0, dout_wr}, 0);
      chk("t5_rst_level", {27'b0, level}, 0);
      chk("t5_rst_ovf", {31'b0, overflow}, 0);
      @(negedge clk);
      din_v = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      seen.delete();
      send_seq(2, 16'h0201, 16'h0001, 0);
      idle(6, 0);
      chk("t5_fresh", seen_at(0), 32'h0202_0201);

`ifdef FU_PACK_TRAILER_EN
      // a new burst starting in the trailer cycle
      seen.delete();
      send_seq(3, 16'h0301, 16'h0001, 0);
      idle(1, 0);
      send_seq(2, 16'h0401, 16'h0001, 0);
      idle(8, 0);
      chk("t6_w0", seen_at(0), 32'h0302_0301);
      chk("t6_w1", seen_at(1), 32'h0000_0303);
      chk("t6_tr1", seen_at(2), 32'hB5E0_0003);
      chk("t6_w3", seen_at(3), 32'h0402_0401);
      chk("t6_tr2", seen_at(4), 32'hB5E0_0002);
`endif

      // randomized bursts and backpressure
      do_reset();
      hf_bias = 0;
      v = 0;
      for (int i = 0; i < 3000; i++) begin
         if ((i % 64) == 0) hf_bias = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) v = ~v;
         tick(v, 16'($urandom), hf_bias ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0));
      end
      idle(40, 0);
      chk("end_level", {27'b0, level}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
